// File: rtl/mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// mem_dump_ctrl
//
// Walks a word-addressed memory from address 0 to N_ADDRESS-1 through its
// debug read port and streams every word out as four bytes, least
// significant byte first, over a valid/ready byte interface.
//
// Ports
//   i_clk       : clock, all state changes on the rising edge
//   i_rst       : asynchronous active-high reset
//   i_start     : dump request, only looked at while idle
//   i_d_r_data  : memory read data, valid one cycle after o_d_en
//   o_d_en      : memory read enable (one cycle per word)
//   o_d_addr    : memory read address (the current word address)
//   o_tx_data   : byte offered to the transmitter
//   o_tx_valid  : o_tx_data is valid
//   i_tx_ready  : transmitter accepts o_tx_data on this edge when valid
//   o_busy      : a dump is in progress
//   o_done      : single-cycle pulse when the last byte has been accepted
// -----------------------------------------------------------------------------
module mem_dump_ctrl #(
  parameter int NB_DATA    = 32,
  parameter int N_ADDRESS  = 32,
  parameter int NB_ADDRESS = $clog2(N_ADDRESS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_DATA-1:0]    i_d_r_data,
  output logic                  o_d_en,
  output logic [NB_ADDRESS-1:0] o_d_addr,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);

  state_t                  state_reg, state_next;
  logic [NB_ADDRESS-1:0]   addr_reg,  addr_next;
  logic [1:0]              cnt_reg,   cnt_next;
  logic [NB_DATA-1:0]      word_reg,  word_next;

  // Byte lanes of the captured word, lane 0 is the first one sent.
  logic [7:0] word_bytes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign word_bytes[gi] = word_reg[gi*8 +: 8];
    end
  endgenerate

  // State registers; reset acts immediately so every output (all of which
  // are decoded from these registers) drops to zero without a clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          addr_next  = '0;
          state_next = REQ;
        end
      end

      // The memory registers its data on the falling edge inside this
      // cycle, so it is already stable at the closing rising edge.
      REQ: begin
        word_next  = i_d_r_data;
        cnt_next   = '0;
        state_next = SEND;
      end

      SEND: begin
        if (i_tx_ready) begin
          if (cnt_reg != 2'd3) begin
            cnt_next = cnt_reg + 2'd1;
          end else if (addr_reg == LAST_ADDR) begin
            // Last word finished: the address stays put, it never wraps.
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = REQ;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    o_d_en     = (state_reg == REQ);
    o_d_addr   = addr_reg;
    o_tx_valid = (state_reg == SEND);
    o_tx_data  = (state_reg == SEND) ? word_bytes[cnt_reg] : 8'd0;
    o_busy     = (state_reg != IDLE);
    o_done     = (state_reg == DONE);
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
module tb_mem_dump_ctrl;

  localparam int N0 = 32;
  localparam int N1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st0, rdy0, den0, txv0, busy0, done0;
  logic [4:0]  addr0;
  logic [7:0]  txd0;
  logic [31:0] rd0;
  logic        st1, rdy1, den1, txv1, busy1, done1;
  logic [1:0]  addr1;
  logic [7:0]  txd1;
  logic [31:0] rd1;

  logic [31:0] mem [2][32];

  mem_dump_ctrl #(.NB_DATA(32), .N_ADDRESS(N0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(st0), .i_d_r_data(rd0),
    .o_d_en(den0), .o_d_addr(addr0), .o_tx_data(txd0), .o_tx_valid(txv0),
    .i_tx_ready(rdy0), .o_busy(busy0), .o_done(done0)
  );

  mem_dump_ctrl #(.NB_DATA(32), .N_ADDRESS(N1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1), .i_d_r_data(rd1),
    .o_d_en(den1), .o_d_addr(addr1), .o_tx_data(txd1), .o_tx_valid(txv1),
    .i_tx_ready(rdy1), .o_busy(busy1), .o_done(done1)
  );

  // Memories answer a read on the falling edge of the request cycle.
  always @(negedge clk) begin
    if (den0) rd0 <= mem[0][addr0];
    if (den1) rd1 <= mem[1][addr1];
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Transaction-level model: which phase of the dump each unit is in,
  // the word being fetched and the position in the flat byte stream.
  bit   m_busy [2];
  bit   m_req  [2];
  bit   m_send [2];
  bit   m_done [2];
  int   m_word [2];
  int   m_pos  [2];
  int   req_cnt [2];
  int   done_cnt [2];
  int   first_req_cyc [2];
  int   done_cyc [2];
  int   req_addr [2][32];
  logic [7:0] got [2][128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte p of the dump stream is byte (p mod 4) of word p/4, LSB first.
  function automatic logic [7:0] exp_byte(input int i, input int p);
    logic [31:0] w;
    w = mem[i][p / 4];
    return w[8 * (p % 4) +: 8];
  endfunction

  task automatic model_cycle(input int i);
    logic en, v, b, d, s, r;
    logic [31:0] a;
    logic [7:0] t;
    int n;
    string u;
    u = $sformatf("u%0d", i);
    if (i == 0) begin
      n = N0; en = den0; a = 32'(addr0); t = txd0; v = txv0; b = busy0; d = done0; s = st0; r = rdy0;
    end else begin
      n = N1; en = den1; a = 32'(addr1); t = txd1; v = txv1; b = busy1; d = done1; s = st1; r = rdy1;
    end

    if (rst) begin
      chk({u, ".rst.d_en"}, en, 0);
      chk({u, ".rst.addr"}, a, 0);
      chk({u, ".rst.tx_data"}, t, 0);
      chk({u, ".rst.tx_valid"}, v, 0);
      chk({u, ".rst.busy"}, b, 0);
      chk({u, ".rst.done"}, d, 0);
      m_busy[i] = 0; m_req[i] = 0; m_send[i] = 0; m_done[i] = 0;
      m_word[i] = 0; m_pos[i] = 0;
      return;
    end

    chk({u, ".busy"}, b, m_busy[i]);
    chk({u, ".d_en"}, en, m_req[i]);
    chk({u, ".addr"}, a, m_word[i]);
    chk({u, ".tx_valid"}, v, m_send[i]);
    chk({u, ".done"}, d, m_done[i]);
    if (m_send[i]) chk({u, ".tx_data"}, t, exp_byte(i, m_pos[i]));

    if (m_req[i]) begin
      if (req_cnt[i] == 0) first_req_cyc[i] = cyc;
      if (req_cnt[i] < 32) req_addr[i][req_cnt[i]] = int'(a);
      req_cnt[i]++;
    end
    if (m_done[i]) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
      chk({u, ".reqs_per_dump"}, req_cnt[i], n);
      chk({u, ".bytes_per_dump"}, m_pos[i], 4 * n);
    end

    // Advance to what the next cycle must look like.
    if (m_done[i]) begin
      m_busy[i] = 0; m_done[i] = 0;
    end else if (!m_busy[i]) begin
      if (s) begin
        m_busy[i] = 1; m_req[i] = 1; m_word[i] = 0; m_pos[i] = 0; req_cnt[i] = 0;
      end
    end else if (m_req[i]) begin
      m_req[i] = 0; m_send[i] = 1;
    end else if (m_send[i] && r) begin
      got[i][m_pos[i]] = t;
      m_pos[i]++;
      if (m_pos[i] % 4 == 0) begin
        m_send[i] = 0;
        if (m_word[i] == n - 1) m_done[i] = 1;
        else begin
          m_word[i]++; m_req[i] = 1;
        end
      end
    end
  endtask

  // One clock: check/advance the model mid-cycle, return just after the
  // next rising edge so the caller can set inputs for the following cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input bit use1, input bit rnd, input bit spur, input bit bp,
                          input int exp_len0, input int exp_len1);
    int guard;
    int bp_left;
    bit spur_used;
    bit bp_used;
    int d0, d1;
    guard = 0; bp_left = 0; spur_used = 0; bp_used = 0;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    rdy0 = 1; rdy1 = 1;
    st0 = 1; st1 = use1;
    step();
    st0 = 0; st1 = 0;
    while ((m_busy[0] || m_busy[1]) && guard < 3000) begin
      guard++;
      st0 = 0; st1 = 0; rdy0 = 1; rdy1 = 1;
      if (rnd) begin
        rdy0 = ($urandom_range(0, 9) < 7);
        rdy1 = ($urandom_range(0, 9) < 7);
        st0  = m_busy[0] && ($urandom_range(0, 7) == 0);
        st1  = m_busy[1] && ($urandom_range(0, 7) == 0);
      end
      if (spur && !spur_used && m_busy[0] && addr0 == 5'd3) begin
        st0 = 1; spur_used = 1;
      end
      if (bp) begin
        if (!bp_used && txv0 && addr0 == 5'd5 && txd0 == 8'hC3) begin
          bp_used = 1; bp_left = 7;
        end
        if (bp_left > 0) begin
          chk("bp.tx_data", txd0, 8'hC3);
          chk("bp.tx_valid", txv0, 1);
          chk("bp.addr", addr0, 5);
          rdy0 = 0;
          bp_left--;
        end
      end
      step();
    end
    rdy0 = 1; rdy1 = 1; st0 = 0; st1 = 0;
    chk("dump.timeout", guard < 3000, 1);
    chk("u0.done_pulses", done_cnt[0] - d0, 1);
    if (use1) chk("u1.done_pulses", done_cnt[1] - d1, 1);
    if (exp_len0 >= 0) chk("u0.req_to_done", done_cyc[0] - first_req_cyc[0], exp_len0);
    if (exp_len1 >= 0) chk("u1.req_to_done", done_cyc[1] - first_req_cyc[1], exp_len1);
    if (spur) chk("spur.issued", spur_used, 1);
    if (bp) chk("bp.seen", bp_used, 1);
  endtask

  initial begin
    logic [7:0] pin_head [8];
    logic [7:0] pin_tail [4];
    logic [7:0] pin_u1 [4];
    int guard;
    int d0;

    pin_head = '{8'h00, 8'h00, 8'hC3, 8'hA5, 8'h01, 8'h00, 8'hC3, 8'hA5};
    pin_tail = '{8'h1F, 8'h00, 8'hC3, 8'hA5};
    pin_u1   = '{8'h00, 8'h56, 8'h34, 8'h12};

    rst = 1; st0 = 0; st1 = 0; rdy0 = 1; rdy1 = 1;
    for (int k = 0; k < 32; k++) begin
      mem[0][k] = 32'hA5C3_0000 | 32'(k);
      mem[1][k] = 32'h1234_5600 | 32'(k);
    end
    #2;
    chk("reset.busy", busy0, 0);
    chk("reset.d_en", den0, 0);
    chk("reset.tx_valid", txv0, 0);
    chk("reset.done", done0, 0);
    repeat (2) step();
    rst = 0;
    step();

    // Plain full dump on both sizes.
    run_dump(1, 0, 0, 0, 5 * N0, 5 * N1);
    for (int k = 0; k < 8; k++) chk($sformatf("u0.head[%0d]", k), got[0][k], pin_head[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("u0.tail[%0d]", k), got[0][124 + k], pin_tail[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("u1.byte[%0d]", k), got[1][k], pin_u1[k]);
    chk("u1.byte[12]", got[1][12], 8'h03);
    for (int k = 0; k < 4; k++) chk($sformatf("u1.req_addr[%0d]", k), req_addr[1][k], k);
    repeat (3) step();

    // Start pulse in the middle of a dump changes nothing.
    run_dump(0, 0, 1, 0, 160, -1);
    repeat (2) step();

    // Seven cycles of backpressure on byte 2 of word 5.
    run_dump(0, 0, 0, 1, 167, -1);
    repeat (2) step();

    // Reset in the middle of word 10.
    st0 = 1; step(); st0 = 0;
    guard = 0;
    while (!(txv0 && addr0 == 5'd10) && guard < 500) begin
      step(); guard++;
    end
    chk("rst.reach_word10", guard < 500, 1);
    d0 = done_cnt[0];
    rst = 1;
    #1;
    chk("rst.async.d_en", den0, 0);
    chk("rst.async.addr", addr0, 0);
    chk("rst.async.tx_data", txd0, 0);
    chk("rst.async.tx_valid", txv0, 0);
    chk("rst.async.busy", busy0, 0);
    chk("rst.async.done", done0, 0);
    step();
    rst = 0;
    repeat (3) step();
    chk("rst.no_done", done_cnt[0] - d0, 0);
    st0 = 1; step(); st0 = 0;
    chk("restart.d_en", den0, 1);
    chk("restart.addr", addr0, 0);
    guard = 0;
    while (m_busy[0] && guard < 1000) begin
      step(); guard++;
    end
    chk("restart.finish", done_cnt[0] - d0, 1);
    repeat (2) step();

    // Random contents, random ready and stray start pulses.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 32; k++) begin
        mem[0][k] = $urandom;
        mem[1][k] = $urandom;
      end
      run_dump(1, 1, 0, 0, -1, -1);
      repeat ($urandom_range(1, 4)) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 Parameter NB_DATA, default 32, SHALL set the memory word width in bits (fixed at 32 for byte slicing).
REQ-002 Parameter N_ADDRESS, default 32, SHALL set the number of memory words to dump.
REQ-003 Parameter NB_ADDRESS, default $clog2(N_ADDRESS), SHALL set the address width.
REQ-004 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 i_start  input  1  SHALL be the dump request, sampled only in IDLE.
REQ-007 i_d_r_data  input  NB_DATA  SHALL be the memory debug read data, valid one cycle after an o_d_en request.
REQ-008 o_d_en  output  1  SHALL be the memory debug read enable.
REQ-009 o_d_addr  output  NB_ADDRESS  SHALL be the memory debug read address.
REQ-010 o_tx_data  output  8  SHALL be the byte offered to the serial transmitter.
REQ-011 o_tx_valid  output  1  SHALL mark o_tx_data as valid.
REQ-012 i_tx_ready  input  1  SHALL be transmitter ready; a byte transfers on a rising edge with o_tx_valid=1 and i_tx_ready=1.
REQ-013 o_busy  output  1  SHALL be high in every state except IDLE.
REQ-014 o_done  output  1  SHALL be a one-cycle pulse when a full dump completes.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, SEND and DONE, held in registers.
REQ-016 IDLE: on i_start=1, address register SHALL clear to 0 and the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-017 REQ: the block SHALL assert o_d_en=1 for exactly one cycle with o_d_addr equal to the address register.
REQ-018 REQ: at the end of the cycle (the memory registers on the falling edge within it), the block SHALL capture i_d_r_data into a word register, clear the byte counter to 0, and go to SEND.
REQ-019 o_d_en SHALL be 0 in every state other than REQ; o_d_addr SHALL always equal the address register.
REQ-020 SEND: o_tx_valid SHALL be 1, and o_tx_data SHALL be the word byte selected by the counter, LSB first: 0->[7:0], 1->[15:8], 2->[23:16], 3->[31:24].
REQ-021 SEND with i_tx_ready=0: o_tx_data, o_tx_valid, the counter and the address SHALL hold unchanged, with no timeout.
REQ-022 SEND with a transfer and counter<3: the counter SHALL increment and the FSM SHALL stay in SEND.
REQ-023 SEND with a transfer and counter=3:
- if the address is N_ADDRESS-1, the FSM SHALL go to DONE.
- otherwise the address SHALL increment by 1 and the FSM SHALL go to REQ.
REQ-024 The address SHALL never exceed N_ADDRESS-1 and SHALL never wrap during a dump.
REQ-025 DONE: o_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-026 i_start SHALL be ignored in REQ, SEND and DONE.
REQ-027 o_tx_valid SHALL be 0 outside SEND; o_done SHALL be 0 outside DONE.
REQ-028 With i_tx_ready held at 1, a dump SHALL take exactly 5*N_ADDRESS cycles from the first REQ to the DONE cycle.

Reset
REQ-029 On i_rst=1, regardless of the clock, the following SHALL be cleared immediately:
- state to IDLE;
- address, byte counter and word register to 0;
- o_d_en, o_tx_valid, o_tx_data, o_busy and o_done to 0.
REQ-030 Reset during a dump SHALL abort it without an o_done pulse; the next i_start SHALL restart at address 0.

Verification
REQ-031 Full dump: mem[k]=32'hA5C3_0000|k, i_tx_ready=1, pulse i_start -> 128 bytes in order 00,00,C3,A5,01,00,C3,A5,...,1F,00,C3,A5; o_done pulses once 160 cycles after the first REQ cycle; o_busy is high throughout.
REQ-032 Backpressure: drop i_tx_ready for 7 cycles while byte 2 of word 5 is offered -> o_tx_data=C3 and o_tx_valid=1 held all 7 cycles; o_d_addr=5 held; no byte lost or duplicated.
REQ-033 Start while busy: pulse i_start during word 3 -> no restart; the byte stream and o_done timing match the REQ-031 scenario.
REQ-034 Reset mid-dump: assert i_rst during SEND of word 10 -> all outputs 0 without a clock edge; no o_done; a new i_start gives o_d_en=1 with o_d_addr=0.
REQ-035 N_ADDRESS=4: full dump -> 16 bytes; o_d_addr sequence 0,1,2,3; DONE entered after address 3; o_done pulses 20 cycles after the first REQ.
REQ-036 Request timing: in every dump, o_d_en is high for exactly one cycle per word, and each captured word equals mem[o_d_addr].
